// File: rtl/arith_result_serializer_if.sv
// Handshake/bus bundle between the arithmetic stage, the serializer and the byte sink.
// The slave modport is the serializer's view; master is the upstream/sink view.
interface arith_result_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] w;
    logic [10:0] x;
    logic [17:0] y;
    logic [10:0] z;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    modport slave (
        input  in_valid, w, x, y, z, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );

    modport master (
        output in_valid, w, x, y, z, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/arith_result_serializer.sv
// Captures one {w,x,y,z} result set and streams it as a header-led little-endian byte frame.
// Optional trailing XOR checksum byte is enabled by defining ARITH_SER_CHECKSUM_EN.
module arith_result_serializer #(
    parameter logic [7:0] SOF_BYTE = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    arith_result_serializer_if.slave    bus
);
    localparam int unsigned HOLD_W = 51;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] DATA_LAST_IDX = 4'd9;
`ifdef ARITH_SER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = 4'd10;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CHK} state_e;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = 4'd9;
    typedef enum logic {ST_IDLE, ST_SEND} state_e;
`endif

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [7:0]         out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               in_ready_q;
    logic               busy_q;
`ifdef ARITH_SER_CHECKSUM_EN
    logic [7:0]         chk_q;
`endif

    logic [IDX_W-1:0]   idx_d;
    logic [7:0]         byte_d;
    logic               last_d;

    // Hold layout: {z[50:40], y[39:22], x[21:11], w[10:0]}
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [HOLD_W-1:0] hold);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = SOF_BYTE;
            4'd1:    b = hold[7:0];
            4'd2:    b = {5'b0, hold[10:8]};
            4'd3:    b = hold[18:11];
            4'd4:    b = {5'b0, hold[21:19]};
            4'd5:    b = hold[29:22];
            4'd6:    b = hold[37:30];
            4'd7:    b = {6'b0, hold[39:38]};
            4'd8:    b = hold[47:40];
            4'd9:    b = {5'b0, hold[50:48]};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Lookahead of the byte presented after the current one is accepted
    always_comb begin
        idx_d  = IDX_W'(idx_q + 4'd1);
        byte_d = frame_byte(idx_d, hold_q);
        last_d = (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef ARITH_SER_CHECKSUM_EN
            chk_q       <= 8'h00;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_q     <= ST_SEND;
                        hold_q      <= {bus.z, bus.y, bus.x, bus.w};
                        idx_q       <= '0;
                        out_data_q  <= SOF_BYTE;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef ARITH_SER_CHECKSUM_EN
                        chk_q       <= 8'h00;
`endif
                    end
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
`ifdef ARITH_SER_CHECKSUM_EN
                        chk_q <= chk_q ^ out_data_q;
`endif
                        if (idx_q == DATA_LAST_IDX) begin
`ifdef ARITH_SER_CHECKSUM_EN
                            // Checksum byte folds in byte 9, which is still on out_data_q
                            state_q    <= ST_CHK;
                            idx_q      <= idx_d;
                            out_data_q <= chk_q ^ out_data_q;
                            out_last_q <= 1'b1;
`else
                            state_q     <= ST_IDLE;
                            idx_q       <= '0;
                            out_data_q  <= 8'h00;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
`endif
                        end else begin
                            idx_q      <= idx_d;
                            out_data_q <= byte_d;
                            out_last_q <= last_d;
                        end
                    end
                end
`ifdef ARITH_SER_CHECKSUM_EN
                ST_CHK: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        idx_q       <= '0;
                        out_data_q  <= 8'h00;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;

endmodule
